spi_master_word_sequencer: RTL and testbench

Upstream control stage for simple_spi_master. It accepts a valid/ready stream of TX words, each tagged with a "last" flag, and drives the master's xfer_enable, xfer_word_trigger and data_tx. It returns each received word on a valid/ready RX stream. It also owns chip-select framing: setup delay, inter-word continuation, hold delay, idle gap, and a completion timeout.

---
 rtl/spi_master_word_sequencer.sv | 237 +++++++++++++++++++++++
 tb/tb_spi_master_word_sequencer.sv | 555 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_word_sequencer.sv
// Word sequencer in front of simple_spi_master: chip-select framing
// (setup, continuation, hold, idle gap), one word in flight, RX return.
//
// Ports:
//   system_clk, system_rst_n        clock, async active-low reset
//   tx_data/tx_last/tx_valid/tx_ready  upstream word stream (last ends frame)
//   rx_data/rx_valid/rx_ready       downstream received-word stream
//   busy                            frame in progress
//   timeout_error                   one-cycle pulse on word timeout
//   xfer_enable/xfer_word_trigger/data_tx   to the SPI master
//   xfer_word_completed/data_rx     from the SPI master

module spi_master_word_sequencer #(
    parameter int WORDWIDTH     = 8,
    parameter int CS_SETUP_CLKS = 2,
    parameter int CS_HOLD_CLKS  = 2,
    parameter int CS_IDLE_CLKS  = 2,
    parameter int TIMEOUT_CLKS  = 0
) (
    input  logic                 system_clk,
    input  logic                 system_rst_n,
    input  logic [WORDWIDTH-1:0] tx_data,
    input  logic                 tx_last,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORDWIDTH-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 busy,
    output logic                 timeout_error,
    output logic                 xfer_enable,
    output logic                 xfer_word_trigger,
    output logic [WORDWIDTH-1:0] data_tx,
    input  logic                 xfer_word_completed,
    input  logic [WORDWIDTH-1:0] data_rx
);

    localparam int MAX_SH = (CS_SETUP_CLKS > CS_HOLD_CLKS) ?
                            CS_SETUP_CLKS : CS_HOLD_CLKS;
    localparam int MAX_SHI = (MAX_SH > CS_IDLE_CLKS) ?
                             MAX_SH : CS_IDLE_CLKS;
    localparam int MAXP = (MAX_SHI > TIMEOUT_CLKS) ?
                          MAX_SHI : TIMEOUT_CLKS;
    localparam int CW = (MAXP < 2) ? 1 : $clog2(MAXP + 1);

    // Terminal counts; a zero parameter is handled by skipping the
    // state, so these never wrap below zero.
    localparam logic [CW-1:0] SETUP_LAST =
        (CS_SETUP_CLKS > 0) ? CW'(CS_SETUP_CLKS - 1) : '0;
    localparam logic [CW-1:0] HOLD_LAST =
        (CS_HOLD_CLKS > 0) ? CW'(CS_HOLD_CLKS - 1) : '0;
    localparam logic [CW-1:0] IDLE_LAST =
        (CS_IDLE_CLKS > 0) ? CW'(CS_IDLE_CLKS - 1) : '0;
    localparam logic [CW-1:0] TMO_LAST =
        (TIMEOUT_CLKS > 0) ? CW'(TIMEOUT_CLKS - 1) : '0;
    localparam logic [CW-1:0] ONE = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_TRIGGER,
        S_WAIT,
        S_NEXT,
        S_HOLD,
        S_GAP
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [CW-1:0]        tmo_cnt_q, tmo_cnt_d;
    logic                 last_q, last_d;
    logic                 xfer_enable_q, xfer_enable_d;
    logic                 trigger_q, trigger_d;
    logic [WORDWIDTH-1:0] data_tx_q, data_tx_d;
    logic [WORDWIDTH-1:0] rx_data_q, rx_data_d;
    logic                 rx_valid_q, rx_valid_d;
    logic                 timeout_q, timeout_d;
    logic                 busy_q, busy_d;

    logic rx_free;
    logic accept;
    logic release_frame;
    logic go_gap;

    assign rx_free  = !rx_valid_q || rx_ready;
    assign tx_ready = ((state_q == S_IDLE) || (state_q == S_NEXT))
                      && rx_free;
    assign accept   = tx_valid && tx_ready;

    assign rx_data           = rx_data_q;
    assign rx_valid          = rx_valid_q;
    assign busy              = busy_q;
    assign timeout_error     = timeout_q;
    assign xfer_enable       = xfer_enable_q;
    assign xfer_word_trigger = trigger_q;
    assign data_tx           = data_tx_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tmo_cnt_d     = tmo_cnt_q;
        last_d        = last_q;
        xfer_enable_d = xfer_enable_q;
        trigger_d     = 1'b0;
        data_tx_d     = data_tx_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q && !rx_ready;
        timeout_d     = 1'b0;
        release_frame = 1'b0;
        go_gap        = 1'b0;

        if (accept) begin
            data_tx_d = tx_data;
            last_d    = tx_last;
        end

        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    xfer_enable_d = 1'b1;
                    if (CS_SETUP_CLKS == 0) begin
                        state_d   = S_TRIGGER;
                        trigger_d = 1'b1;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = SETUP_LAST;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d   = S_TRIGGER;
                    trigger_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_TRIGGER: begin
                // Counter holds "cycles since trigger" while in WAIT.
                state_d   = S_WAIT;
                tmo_cnt_d = ONE;
            end
            S_WAIT: begin
                if (xfer_word_completed) begin
                    rx_data_d  = data_rx;
                    rx_valid_d = 1'b1;
                    if (last_q) begin
                        release_frame = 1'b1;
                    end else begin
                        state_d = S_NEXT;
                    end
                end else if ((TIMEOUT_CLKS != 0) &&
                             (tmo_cnt_q >= TMO_LAST)) begin
                    // Abort the whole frame regardless of last flag.
                    timeout_d     = 1'b1;
                    release_frame = 1'b1;
                end else if (TIMEOUT_CLKS != 0) begin
                    tmo_cnt_d = tmo_cnt_q + ONE;
                end
            end
            S_NEXT: begin
                if (accept) begin
                    state_d   = S_TRIGGER;
                    trigger_d = 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    go_gap = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d       = S_IDLE;
                xfer_enable_d = 1'b0;
            end
        endcase

        if (release_frame) begin
            if (CS_HOLD_CLKS != 0) begin
                state_d = S_HOLD;
                cnt_d   = HOLD_LAST;
            end else begin
                go_gap = 1'b1;
            end
        end

        if (go_gap) begin
            xfer_enable_d = 1'b0;
            if (CS_IDLE_CLKS != 0) begin
                state_d = S_GAP;
                cnt_d   = IDLE_LAST;
            end else begin
                state_d = S_IDLE;
            end
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge system_clk or negedge system_rst_n) begin
        if (!system_rst_n) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            tmo_cnt_q     <= '0;
            last_q        <= 1'b0;
            xfer_enable_q <= 1'b0;
            trigger_q     <= 1'b0;
            data_tx_q     <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            timeout_q     <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            last_q        <= last_d;
            xfer_enable_q <= xfer_enable_d;
            trigger_q     <= trigger_d;
            data_tx_q     <= data_tx_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            timeout_q     <= timeout_d;
            busy_q        <= busy_d;
        end
    end

endmodule

// File: tb/tb_spi_master_word_sequencer.sv
// Testbench for spi_master_word_sequencer: behavioural SPI master/slave
// stand-in, event monitor, and per-scenario self-checking tasks.

module tb_spi_master_word_sequencer;

    localparam int WW    = 4;
    localparam int SETUP = 2;
    localparam int HOLD  = 2;
    localparam int IDLE  = 2;
    localparam int TMO   = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [WW-1:0] tx_data = '0;
    logic          tx_last = 1'b0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic [WW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready = 1'b0;
    logic          busy;
    logic          timeout_error;
    logic          xfer_enable;
    logic          xfer_word_trigger;
    logic [WW-1:0] data_tx;
    logic          xfer_word_completed = 1'b0;
    logic [WW-1:0] data_rx = '0;

    int errors = 0;
    int checks = 0;

    spi_master_word_sequencer #(
        .WORDWIDTH(WW),
        .CS_SETUP_CLKS(SETUP),
        .CS_HOLD_CLKS(HOLD),
        .CS_IDLE_CLKS(IDLE),
        .TIMEOUT_CLKS(TMO)
    ) dut (
        .system_clk(clk),
        .system_rst_n(rst_n),
        .tx_data(tx_data),
        .tx_last(tx_last),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .busy(busy),
        .timeout_error(timeout_error),
        .xfer_enable(xfer_enable),
        .xfer_word_trigger(xfer_word_trigger),
        .data_tx(data_tx),
        .xfer_word_completed(xfer_word_completed),
        .data_rx(data_rx)
    );

    always #5 clk = ~clk;

    // Master + slave stand-in: completes each trigger after a random
    // latency, returning the next queued slave word.
    logic [WW-1:0] slave_q[$];
    bit            stub_dead = 1'b0;
    bit            pend = 1'b0;
    int            cd = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0;
            xfer_word_completed = 1'b0;
        end else begin
            xfer_word_completed = 1'b0;
            if (pend) begin
                cd = cd - 1;
                if (cd == 0) begin
                    pend = 1'b0;
                    xfer_word_completed = 1'b1;
                    if (slave_q.size() > 0) data_rx = slave_q.pop_front();
                    else data_rx = '0;
                end
            end
            if (xfer_word_trigger && !stub_dead) begin
                pend = 1'b1;
                cd = $urandom_range(3, 12);
            end
        end
    end

    // Event monitor: timestamps of framing events and delivered words.
    int            cyc = 0;
    int            en_rise_t[$];
    int            en_fall_t[$];
    int            trig_t[$];
    logic [WW-1:0] trig_d[$];
    int            rxv_t[$];
    logic [WW-1:0] rx_got[$];
    int            tmo_t[$];
    bit            prev_en = 1'b0;
    bit            prev_rxv = 1'b0;
    bit            prev_hs = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        #1;
        if (xfer_enable && !prev_en) en_rise_t.push_back(cyc);
        if (!xfer_enable && prev_en) en_fall_t.push_back(cyc);
        if (xfer_word_trigger) begin
            trig_t.push_back(cyc);
            trig_d.push_back(data_tx);
        end
        if (rx_valid && (!prev_rxv || prev_hs)) rxv_t.push_back(cyc);
        if (rx_valid && rx_ready) rx_got.push_back(rx_data);
        if (timeout_error) tmo_t.push_back(cyc);
        prev_en  = xfer_enable;
        prev_rxv = rx_valid;
        prev_hs  = rx_valid && rx_ready;
    end

    task automatic clear_mon();
        en_rise_t.delete();
        en_fall_t.delete();
        trig_t.delete();
        trig_d.delete();
        rxv_t.delete();
        rx_got.delete();
        tmo_t.delete();
    endtask

    // Offer one word until accepted; ok=0 if never accepted.
    task automatic push_word(input logic [WW-1:0] d, input bit last,
                             output bit ok);
        ok = 1'b0;
        tx_data = d;
        tx_last = last;
        tx_valid = 1'b1;
        for (int i = 0; i < 300 && !ok; i++) begin
            #1;
            if (tx_ready) ok = 1'b1;
            @(negedge clk);
        end
        tx_valid = 1'b0;
    endtask

    task automatic wait_idle(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 500 && !ok; i++) begin
            @(negedge clk);
            if (!busy) ok = 1'b1;
        end
    endtask

    task automatic wait_rxv(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (rx_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [3*WW+6:0] got;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        got = {xfer_enable, xfer_word_trigger, data_tx, rx_data,
               rx_valid, timeout_error, busy, 1'b0};
        checks++;
        if (got !== '0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=0", got);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle tx_ready=%b busy=%b want 1/0",
                     tx_ready, busy);
        end
    endtask

    task automatic test_single();
        bit ok;
        bit exp_en, exp_txr, exp_rxv;
        clear_mon();
        rx_ready = 1'b0;
        slave_q.push_back(4'b1010);
        push_word(4'b0110, 1'b1, ok);
        wait_rxv(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_rx_timeout rx_valid never set");
        end
        checks++;
        if (rx_data !== 4'b1010) begin
            errors++;
            $display("FAIL single_rx_data got=%b want=1010", rx_data);
        end
        for (int k = 0; k < 7; k++) begin
            exp_en  = (k < HOLD);
            exp_txr = (k >= HOLD + IDLE);
            exp_rxv = (k <= 2);
            checks++;
            if (xfer_enable !== exp_en || tx_ready !== exp_txr ||
                rx_valid !== exp_rxv) begin
                errors++;
                $display("FAIL single_tail k=%0d en/txr/rxv=%b%b%b want %b%b%b",
                         k, xfer_enable, tx_ready, rx_valid,
                         exp_en, exp_txr, exp_rxv);
            end
            if (k == 2) rx_ready = 1'b1;
            if (k == 3) rx_ready = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (trig_t.size() != 1 || en_rise_t.size() != 1) begin
            errors++;
            $display("FAIL single_counts trig=%0d rise=%0d want 1/1",
                     trig_t.size(), en_rise_t.size());
        end else begin
            checks++;
            if (trig_t[0] - en_rise_t[0] != SETUP) begin
                errors++;
                $display("FAIL single_setup got=%0d want=%0d",
                         trig_t[0] - en_rise_t[0], SETUP);
            end
            checks++;
            if (trig_d[0] !== 4'b0110) begin
                errors++;
                $display("FAIL single_data_tx got=%b want=0110",
                         trig_d[0]);
            end
        end
    endtask

    task automatic test_frame();
        bit ok;
        logic [WW-1:0] tx_w[3] = '{4'b1010, 4'b0101, 4'b1100};
        logic [WW-1:0] sl_w[3] = '{4'b0000, 4'b1111, 4'b0000};
        clear_mon();
        rx_ready = 1'b1;
        for (int i = 0; i < 3; i++) slave_q.push_back(sl_w[i]);
        for (int i = 0; i < 3; i++) push_word(tx_w[i], i == 2, ok);
        wait_idle(ok);
        repeat (3) @(negedge clk);
        checks++;
        if (en_rise_t.size() != 1 || en_fall_t.size() != 1 ||
            trig_t.size() != 3) begin
            errors++;
            $display("FAIL frame_counts rise=%0d fall=%0d trig=%0d want 1/1/3",
                     en_rise_t.size(), en_fall_t.size(), trig_t.size());
        end
        checks++;
        if (rx_got.size() != 3 || trig_d.size() != 3) begin
            errors++;
            $display("FAIL frame_words rx=%0d tx=%0d want 3/3",
                     rx_got.size(), trig_d.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_got[i] !== sl_w[i] || trig_d[i] !== tx_w[i]) begin
                    errors++;
                    $display("FAIL frame_word%0d rx=%b tx=%b want %b %b",
                             i, rx_got[i], trig_d[i], sl_w[i], tx_w[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        clear_mon();
        rx_ready = 1'b0;
        slave_q.push_back(4'h3);
        slave_q.push_back(4'hC);
        push_word(4'h9, 1'b0, ok);
        wait_rxv(ok);
        tx_data = 4'h6;
        tx_last = 1'b1;
        tx_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (tx_ready || xfer_word_trigger || !xfer_enable) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_stall bad_cycles=%0d want=0", bad);
        end
        rx_ready = 1'b1;
        #1;
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready got=%b want=1", tx_ready);
        end
        @(negedge clk);
        rx_ready = 1'b0;
        tx_valid = 1'b0;
        checks++;
        if (xfer_word_trigger !== 1'b1 || data_tx !== 4'h6 ||
            rx_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_trigger trig=%b data_tx=%h rxv=%b want 1 6 0",
                     xfer_word_trigger, data_tx, rx_valid);
        end
        wait_rxv(ok);
        checks++;
        if (!ok || rx_data !== 4'hC) begin
            errors++;
            $display("FAIL bp_rx2 ok=%b got=%h want=c", ok, rx_data);
        end
        rx_ready = 1'b1;
        wait_idle(ok);
        @(negedge clk);
        checks++;
        if (rx_got.size() != 2 || rx_got[0] !== 4'h3) begin
            errors++;
            $display("FAIL bp_order n=%0d want 2 words, first 3",
                     rx_got.size());
        end
    endtask

    task automatic test_stall_next();
        bit ok;
        int bad;
        clear_mon();
        rx_ready = 1'b1;
        slave_q.push_back(4'h5);
        slave_q.push_back(4'hA);
        push_word(4'h1, 1'b0, ok);
        wait_rxv(ok);
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            if (!xfer_enable || xfer_word_trigger || !busy) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL stall_next bad_cycles=%0d want=0", bad);
        end
        push_word(4'h2, 1'b1, ok);
        wait_idle(ok);
        repeat (2) @(negedge clk);
        checks++;
        if (trig_d.size() != 2 || rx_got.size() != 2 ||
            en_rise_t.size() != 1) begin
            errors++;
            $display("FAIL stall_counts trig=%0d rx=%0d rise=%0d want 2/2/1",
                     trig_d.size(), rx_got.size(), en_rise_t.size());
        end else begin
            checks++;
            if (trig_d[1] !== 4'h2 || rx_got[1] !== 4'hA) begin
                errors++;
                $display("FAIL stall_word2 tx=%h rx=%h want 2 a",
                         trig_d[1], rx_got[1]);
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        int i;
        clear_mon();
        stub_dead = 1'b1;
        rx_ready = 1'b1;
        push_word(4'hE, 1'b1, ok);
        ok = 1'b0;
        for (i = 0; i < 100 && !ok; i++) begin
            if (timeout_error) ok = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL tmo_missing timeout_error never pulsed");
        end
        @(negedge clk);
        checks++;
        if (timeout_error !== 1'b0) begin
            errors++;
            $display("FAIL tmo_width got=%b want=0", timeout_error);
        end
        wait_idle(ok);
        @(negedge clk);
        #1;
        checks++;
        if (!ok || tx_ready !== 1'b1 || rxv_t.size() != 0) begin
            errors++;
            $display("FAIL tmo_idle ok=%b tx_ready=%b rx_words=%0d",
                     ok, tx_ready, rxv_t.size());
        end
        checks++;
        if (tmo_t.size() != 1 || trig_t.size() != 1 ||
            en_fall_t.size() != 1) begin
            errors++;
            $display("FAIL tmo_counts tmo=%0d trig=%0d fall=%0d want 1/1/1",
                     tmo_t.size(), trig_t.size(), en_fall_t.size());
        end else begin
            checks++;
            if (tmo_t[0] - trig_t[0] != TMO ||
                en_fall_t[0] - tmo_t[0] != HOLD) begin
                errors++;
                $display("FAIL tmo_timing tmo=%0d fall=%0d want %0d %0d",
                         tmo_t[0] - trig_t[0], en_fall_t[0] - tmo_t[0],
                         TMO, HOLD);
            end
        end
        stub_dead = 1'b0;
    endtask

    task automatic test_reset_wait();
        bit ok;
        clear_mon();
        rx_ready = 1'b1;
        slave_q.push_back(4'h7);
        push_word(4'hB, 1'b1, ok);
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (xfer_word_trigger) ok = 1'b1;
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (!ok || xfer_enable !== 1'b0 || data_tx !== '0 ||
            rx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_wait trig_seen=%b en=%b dtx=%h rxv=%b busy=%b",
                     ok, xfer_enable, data_tx, rx_valid, busy);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        slave_q.delete();
        @(negedge clk);
        clear_mon();
        slave_q.push_back(4'h4);
        push_word(4'hD, 1'b1, ok);
        wait_rxv(ok);
        checks++;
        if (!ok || rx_data !== 4'h4 || data_tx !== 4'hD) begin
            errors++;
            $display("FAIL rst_after ok=%b rx=%h dtx=%h want 4 d",
                     ok, rx_data, data_tx);
        end
        wait_idle(ok);
        @(negedge clk);
    endtask

    task automatic test_random();
        bit ok;
        bit done;
        logic [WW-1:0] d, s;
        logic [WW-1:0] exp_tx[$];
        logic [WW-1:0] exp_rx[$];
        int first_idx[6];
        int n, widx;
        clear_mon();
        done = 1'b0;
        widx = 0;
        fork
            begin
                for (int f = 0; f < 6; f++) begin
                    n = $urandom_range(1, 4);
                    first_idx[f] = widx;
                    for (int w = 0; w < n; w++) begin
                        d = 4'($urandom_range(0, 15));
                        s = 4'($urandom_range(0, 15));
                        exp_tx.push_back(d);
                        exp_rx.push_back(s);
                        slave_q.push_back(s);
                        push_word(d, w == n - 1, ok);
                        widx++;
                    end
                end
                wait_idle(ok);
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(negedge clk);
                    rx_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        rx_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (trig_d.size() != exp_tx.size() ||
            rx_got.size() != exp_rx.size()) begin
            errors++;
            $display("FAIL rand_counts tx=%0d/%0d rx=%0d/%0d",
                     trig_d.size(), exp_tx.size(),
                     rx_got.size(), exp_rx.size());
        end else begin
            for (int i = 0; i < exp_tx.size(); i++) begin
                checks++;
                if (trig_d[i] !== exp_tx[i] || rx_got[i] !== exp_rx[i]) begin
                    errors++;
                    $display("FAIL rand_word%0d tx=%h rx=%h want %h %h", i,
                             trig_d[i], rx_got[i], exp_tx[i], exp_rx[i]);
                end
            end
        end
        checks++;
        if (en_rise_t.size() != 6 || en_fall_t.size() != 6) begin
            errors++;
            $display("FAIL rand_frames rise=%0d fall=%0d want 6/6",
                     en_rise_t.size(), en_fall_t.size());
        end else if (trig_t.size() == exp_tx.size()) begin
            for (int f = 0; f < 6; f++) begin
                checks++;
                if (trig_t[first_idx[f]] - en_rise_t[f] != SETUP) begin
                    errors++;
                    $display("FAIL rand_setup f=%0d got=%0d want=%0d", f,
                             trig_t[first_idx[f]] - en_rise_t[f], SETUP);
                end
                if (f > 0) begin
                    checks++;
                    if (en_rise_t[f] - en_fall_t[f-1] < IDLE) begin
                        errors++;
                        $display("FAIL rand_gap f=%0d got=%0d min=%0d", f,
                                 en_rise_t[f] - en_fall_t[f-1], IDLE);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_frame();
        test_backpressure();
        test_stall_next();
        test_timeout();
        test_reset_wait();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
